// File: rtl/lmsm_pkg.sv
// Shared definitions for the LM/SM/LA/SA micro-op sequencer: state encoding,
// memory-transfer opcodes and the default register-file size.
package lmsm_pkg;

    // Architectural register count; this is also the width of the LM/SM mask.
    localparam int NREG_DEF = 8;

    // Sequencer states. WB is reachable only when LMSM_BASE_WB_EN is defined.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;

    // instr[15:12] encodings handled here. Bit 1 selects "all registers"
    // (LA/SA). Bit 0 selects store (SM/SA).
    localparam logic [3:0] OP_LM = 4'b1100;
    localparam logic [3:0] OP_SM = 4'b1101;
    localparam logic [3:0] OP_LA = 4'b1110;
    localparam logic [3:0] OP_SA = 4'b1111;

    // Only these four opcodes may start a sequence. Any other opcode is ignored.
    function automatic logic op_legal(input logic [3:0] op);
        return (op == OP_LM) || (op == OP_SM) || (op == OP_LA) || (op == OP_SA);
    endfunction

endpackage

// File: rtl/lm_sm_sequencer_lsb_find.sv
// Lowest-set-bit priority encoder. R0 has the highest priority.
// idx is 0 when no bit is set; 'any' tells the caller whether idx is meaningful.
module lsb_find
    import lmsm_pkg::*;
#(
    parameter int NREG = NREG_DEF
) (
    input  logic [NREG-1:0] vec,
    output logic [2:0]      idx,
    output logic            any
);

    // Scan from the top so the lowest set bit is the last one written and wins.
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (vec[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM/LA/SA sequencer. It accepts one multi-register memory instruction from
// decode and expands it into single-register micro-ops in ascending register
// order. Each micro-op gets an incrementing address. Fetch/decode stay stalled
// until the sequence finishes.
// Optional build macro: LMSM_BASE_WB_EN. When defined, the sequencer adds a
// final micro-op that writes the updated base back to Ra. This micro-op is
// flagged on uop_wb.
module lm_sm_sequencer
    import lmsm_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int NREG      = NREG_DEF,
    parameter int ADDR_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              start_ready,
    input  logic [3:0]        opcode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [NREG-1:0]   reg_mask,
    input  logic [2:0]        ra_idx,
    input  logic              flush,
    output logic              uop_valid,
    input  logic              uop_ready,
    output logic [2:0]        uop_reg,
    output logic [ADDR_W-1:0] uop_addr,
    output logic              uop_store,
    output logic              stall,
    output logic              done
`ifdef LMSM_BASE_WB_EN
   ,output logic              uop_wb
`endif
);

    logic [1:0]        state_q, state_d;
    logic [NREG-1:0]   mask_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] count_q;
    logic [2:0]        ra_q;
    logic              store_q;

    logic [NREG-1:0]   mask_in;
    logic [NREG-1:0]   find_vec;
    logic [NREG-1:0]   mask_clr;
    logic [2:0]        lsb_idx;
    logic              lsb_any;
    logic              accept;
    logic [ADDR_W-1:0] cur_addr;

    // LA/SA move every register, so the instruction's mask field is ignored.
    assign mask_in = opcode[1] ? {NREG{1'b1}} : reg_mask;
    assign accept  = start && (state_q == S_IDLE) && op_legal(opcode);

    // The encoder is shared between two uses:
    // - In IDLE it looks at the incoming mask, so the empty-mask case is known
    //   at accept time.
    // - Afterwards it walks the latched remaining mask.
    assign find_vec = (state_q == S_IDLE) ? mask_in : mask_q;

    lsb_find #(.NREG(NREG)) u_lsb_find (
        .vec (find_vec),
        .idx (lsb_idx),
        .any (lsb_any)
    );

    // Remaining mask after the current micro-op is accepted.
    assign mask_clr = mask_q & ~(NREG'(1) << lsb_idx);

    // Address of the n-th transfer. Wraps modulo 2^ADDR_W by truncation.
    // After the last transfer this value is also the updated base.
    assign cur_addr = base_q + count_q * ADDR_W'(ADDR_STEP);

    // Next-state selection. flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef LMSM_BASE_WB_EN
                    state_d = lsb_any ? S_ISSUE : S_WB;
`else
                    state_d = lsb_any ? S_ISSUE : S_DONE;
`endif
                end
            end
            S_ISSUE: begin
                if (uop_ready && (mask_clr == '0)) begin
`ifdef LMSM_BASE_WB_EN
                    state_d = S_WB;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef LMSM_BASE_WB_EN
            S_WB: begin
                if (uop_ready) state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // State register.
    // - IDLE: latch the instruction on accept.
    // - ISSUE: retire one mask bit per handshake.
    // - flush: drop any remaining work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            base_q  <= '0;
            count_q <= '0;
            ra_q    <= '0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                mask_q  <= '0;
                count_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept) begin
                            mask_q  <= mask_in;
                            base_q  <= base_addr;
                            ra_q    <= ra_idx;
                            store_q <= opcode[0];
                            count_q <= '0;
                        end
                    end
                    S_ISSUE: begin
                        if (uop_ready) begin
                            mask_q  <= mask_clr;
                            count_q <= count_q + ADDR_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs decode straight from registered state. They are therefore stable
    // under backpressure, and they follow an asynchronous reset immediately.
    always_comb begin
        start_ready = (state_q == S_IDLE);
        stall       = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        uop_valid   = 1'b0;
        uop_reg     = '0;
        uop_addr    = '0;
        uop_store   = 1'b0;
`ifdef LMSM_BASE_WB_EN
        uop_wb      = 1'b0;
`endif
        case (state_q)
            S_ISSUE: begin
                uop_valid = 1'b1;
                uop_reg   = lsb_idx;
                uop_addr  = cur_addr;
                uop_store = store_q;
            end
`ifdef LMSM_BASE_WB_EN
            S_WB: begin
                uop_valid = 1'b1;
                uop_reg   = ra_q;
                uop_addr  = cur_addr;
                uop_wb    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

`ifndef LMSM_BASE_WB_EN
    // Without base write-back, Ra is captured but has no consumer.
    logic unused_ra;
    assign unused_ra = ^ra_q;
`endif

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Scoreboard bench for lm_sm_sequencer.
// The stimulus tasks push the expected micro-op stream and done pulses at issue
// time. A negedge monitor pops and compares on every handshake and done pulse.
module tb_lm_sm_sequencer;

`ifdef LMSM_BASE_WB_EN
    localparam int WB = 1;
`else
    localparam int WB = 0;
`endif

    typedef struct {
        logic [2:0]  r;
        logic [15:0] a;
        logic        s;
        logic        wb;
    } uop_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start_ready;
    logic [3:0]  opcode = 4'h0;
    logic [15:0] base_addr = 16'h0;
    logic [7:0]  reg_mask = 8'h0;
    logic [2:0]  ra_idx = 3'h0;
    logic        flush = 1'b0;
    logic        uop_valid;
    logic        uop_ready = 1'b0;
    logic [2:0]  uop_reg;
    logic [15:0] uop_addr;
    logic        uop_store;
    logic        stall;
    logic        done;
`ifdef LMSM_BASE_WB_EN
    logic        uop_wb;
`endif

    lm_sm_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_ready (start_ready),
        .opcode      (opcode),
        .base_addr   (base_addr),
        .reg_mask    (reg_mask),
        .ra_idx      (ra_idx),
        .flush       (flush),
        .uop_valid   (uop_valid),
        .uop_ready   (uop_ready),
        .uop_reg     (uop_reg),
        .uop_addr    (uop_addr),
        .uop_store   (uop_store),
        .stall       (stall),
        .done        (done)
`ifdef LMSM_BASE_WB_EN
       ,.uop_wb      (uop_wb)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    uop_t exp_q[$];
    int   exp_done = 0;
    int   acc_cyc = 0, done_cyc = 0, stall_cnt = 0, valid_cnt = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: fixed pattern
    logic hold = 1'b0;
    logic [19:0] hold_v;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: walk the mask from R0 upwards. Address = base + n*STEP.
    task automatic push_seq(input logic [3:0] op, input logic [15:0] b,
                            input logic [7:0] m, input logic [2:0] r);
        logic [7:0]  mm;
        logic [15:0] n;
        mm = op[1] ? 8'hFF : m;
        n  = 16'd0;
        for (int i = 0; i < 8; i++) begin
            if (mm[i]) begin
                exp_q.push_back('{r: 3'(i), a: b + n, s: op[0], wb: 1'b0});
                n++;
            end
        end
        if (WB == 1) exp_q.push_back('{r: r, a: b + n, s: 1'b0, wb: 1'b1});
        exp_done++;
    endtask

    // Downstream ready generator.
    // Pattern mode replays 0,0,1,0,1 from the first busy cycle onwards.
    initial begin
        bit pat[5];
        int pidx;
        pat  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        pidx = 0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: uop_ready = 1'b1;
                1: uop_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (stall) begin
                        uop_ready = (pidx < 5) ? pat[pidx] : 1'b1;
                        pidx++;
                    end else begin
                        uop_ready = 1'b0;
                        pidx = 0;
                    end
                end
            endcase
        end
    end

    // Monitor and scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_done = 0;
            hold = 1'b0;
        end else begin
            if (start && start_ready && opcode[3:2] == 2'b11) begin
                acc_cyc = cyc; stall_cnt = 0; valid_cnt = 0;
            end
            if (stall) stall_cnt++;
            if (uop_valid) valid_cnt++;
            if (hold && uop_valid)
                chk("stable_under_backpressure", 32'({uop_reg, uop_addr, uop_store}), 32'(hold_v));
            if (uop_valid && uop_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_uop", 32'(uop_reg), 32'hFFFF_FFFF);
                end else begin
                    uop_t e;
                    e = exp_q.pop_front();
                    chk("uop_reg", 32'(uop_reg), 32'(e.r));
                    chk("uop_addr", 32'(uop_addr), 32'(e.a));
                    chk("uop_store", 32'(uop_store), 32'(e.s));
`ifdef LMSM_BASE_WB_EN
                    chk("uop_wb", 32'(uop_wb), 32'(e.wb));
`endif
                end
            end
            if (done) begin
                done_cyc = cyc;
                chk("done_expected", 32'(exp_done > 0), 32'd1);
                if (exp_done > 0) exp_done--;
            end
            hold   = uop_valid && !uop_ready && !flush;
            hold_v = {uop_reg, uop_addr, uop_store};
            if (flush) begin
                exp_q.delete();
                exp_done = 0;
            end
        end
    end

    // Hold start with the instruction fields until the sequencer is idle and
    // takes it. Returns one step after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [15:0] b,
                         input logic [7:0] m, input logic [2:0] r);
        int t;
        opcode = op; base_addr = b; reg_mask = m; ra_idx = r;
        start = 1'b1;
        push_seq(op, b, m, r);
        t = 0;
        @(negedge clk);
        while (!start_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) chk("accept_timeout", 32'(t), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (t < 500) begin
            @(negedge clk);
            if (start_ready && !start && exp_q.size() == 0 && exp_done == 0) break;
            t++;
        end
        chk("sequence_complete", 32'(t < 500), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_start_ready", 32'(start_ready), 32'd1);
        chk("rst_uop_valid", 32'(uop_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_uop_addr", 32'(uop_addr), 32'd0);
        chk("rst_uop_reg", 32'(uop_reg), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LM 0x0100, mask A5, always ready
        ready_mode = 0;
        issue(4'b1100, 16'h0100, 8'hA5, 3'd3);
        wait_idle();
        chk("lm_done_latency", 32'(done_cyc - acc_cyc), 32'(5 + WB));
        chk("lm_stall_cycles", 32'(stall_cnt), 32'(5 + WB));

        // SA from 0xFFFE: address wraps through 0000
        issue(4'b1111, 16'hFFFE, 8'h00, 3'd5);
        wait_idle();
        chk("sa_uop_count", 32'(valid_cnt), 32'(8 + WB));

        // SM with backpressure pattern
        ready_mode = 2;
        issue(4'b1101, 16'h0000, 8'h12, 3'd1);
        wait_idle();
        ready_mode = 0;

        // LM with empty mask
        issue(4'b1100, 16'h1234, 8'h00, 3'd6);
        wait_idle();
        chk("zero_mask_done_latency", 32'(done_cyc - acc_cyc), 32'(1 + WB));
        chk("zero_mask_uops", 32'(valid_cnt), 32'(WB));

        // Illegal opcode must not be accepted
        opcode = 4'b0101; base_addr = 16'h0042; reg_mask = 8'hFF; start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("illegal_start_ready", 32'(start_ready), 32'd1);
            chk("illegal_stall", 32'(stall), 32'd0);
        end
        @(posedge clk); #1;
        start = 1'b0;

        // Flush on the third micro-op
        issue(4'b1100, 16'h0200, 8'hFF, 3'd2);
        repeat (2) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_uop_valid", 32'(uop_valid), 32'd0);
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_start_ready", 32'(start_ready), 32'd1);
        issue(4'b1101, 16'h0300, 8'h81, 3'd4);
        wait_idle();

        // Asynchronous reset mid-ISSUE
        ready_mode = 1;
        issue(4'b1100, 16'h0400, 8'hFF, 3'd0);
        repeat (3) @(posedge clk);
        #2;
        chk("pre_reset_valid", 32'(uop_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_uop_valid", 32'(uop_valid), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_start_ready", 32'(start_ready), 32'd1);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Random instructions. Half are issued while the previous one is still
        // running, so start stays asserted through the busy period.
        for (int n = 0; n < 40; n++) begin
            ready_mode = int'($urandom_range(0, 1));
            issue(4'b1100 + 4'($urandom_range(0, 3)), 16'($urandom), 8'($urandom),
                  3'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule
